// File: rtl/motoro3_step_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// motoro3_step_sequencer : 12-step commutation sequencer with per-step length latch
// Revision 1.0
// ---------------------------------------------------------------------------
module motoro3_step_sequencer #(
  parameter int CNT_W   = 25,
  parameter int MIN_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             fault,
  input  logic             dir,
  input  logic [CNT_W-1:0] m3r_stepLen,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst2,
  output logic             m3cntFirst1,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic             cycleDone,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  state_t           state, state_n;
  logic [3:0]       step_n, step_adv;
  logic [CNT_W-1:0] cnt_n, len, len_n, len_req;
  logic             dir_q, dir_n;
  logic             stop_pend, pend_n;
  logic             active_n;

  function automatic logic [3:0] closing_step(input logic d);
    return d ? 4'd0 : 4'd11;
  endfunction

  assign len_req  = (m3r_stepLen < MIN_L) ? MIN_L : m3r_stepLen;
  assign step_adv = dir ? ((sgStep == 4'd0)  ? 4'd11 : sgStep - 4'd1)
                        : ((sgStep == 4'd11) ? 4'd0  : sgStep + 4'd1);

  always_comb begin
    state_n = state;
    step_n  = sgStep;
    cnt_n   = m3cnt;
    len_n   = len;
    dir_n   = dir_q;
    pend_n  = stop_pend;
    case (state)
      S_IDLE: begin
        if (start && !fault) state_n = S_ARM;
      end
      S_ARM: begin
        len_n   = len_req;
        dir_n   = dir;
        step_n  = dir ? 4'd11 : 4'd0;
        cnt_n   = len_req - ONE;
        state_n = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if (state == S_RUN && stop) pend_n = 1'b1;
        if (m3cnt == '0) begin
          if (state == S_DRAIN) begin
            state_n = S_IDLE;
            step_n  = 4'd0;
            pend_n  = 1'b0;
          end else begin
            dir_n  = dir;
            step_n = step_adv;
            len_n  = len_req;
            cnt_n  = len_req - ONE;
            if (pend_n && step_adv == closing_step(dir)) state_n = S_DRAIN;
          end
        end else begin
          cnt_n = m3cnt - ONE;
          // stop landing inside the closing step drains the remainder of that step
          if (state == S_RUN && pend_n && sgStep == closing_step(dir_q)) state_n = S_DRAIN;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (fault && state != S_IDLE) begin
      state_n = S_IDLE;
      step_n  = 4'd0;
      cnt_n   = '0;
      pend_n  = 1'b0;
    end
  end

  assign active_n = (state_n == S_RUN) || (state_n == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sgStep       <= 4'd0;
      m3cnt        <= '0;
      len          <= MIN_L;
      dir_q        <= 1'b0;
      stop_pend    <= 1'b0;
      m3cntFirst2  <= 1'b0;
      m3cntFirst1  <= 1'b0;
      m3cntLast2   <= 1'b0;
      m3cntLast1   <= 1'b0;
      pwmActive1   <= 1'b0;
      pwmLastStep1 <= 1'b0;
      cycleDone    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      sgStep       <= step_n;
      m3cnt        <= cnt_n;
      len          <= len_n;
      dir_q        <= dir_n;
      stop_pend    <= pend_n;
      m3cntFirst2  <= active_n && (cnt_n == len_n - ONE);
      m3cntFirst1  <= active_n && (cnt_n == len_n - TWO);
      m3cntLast2   <= active_n && (cnt_n == ONE);
      m3cntLast1   <= active_n && (cnt_n == '0);
      pwmActive1   <= active_n;
      pwmLastStep1 <= (state_n == S_DRAIN);
      cycleDone    <= active_n && (cnt_n == '0) && (step_n == closing_step(dir_n));
      busy         <= (state_n != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motoro3_step_sequencer.sv
`default_nettype none
// Testbench for motoro3_step_sequencer: directed scenarios plus random traffic
// against a step/position reference model.
module tb_motoro3_step_sequencer;
  localparam int CNT_W   = 25;
  localparam int MIN_LEN = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, fault, dir;
  logic [CNT_W-1:0] m3r_stepLen;
  logic [3:0]       sgStep;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
  logic             pwmActive1, pwmLastStep1, cycleDone, busy;

  motoro3_step_sequencer #(.CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fault(fault), .dir(dir),
    .m3r_stepLen(m3r_stepLen), .sgStep(sgStep), .m3cnt(m3cnt),
    .m3cntFirst2(m3cntFirst2), .m3cntFirst1(m3cntFirst1),
    .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
    .pwmActive1(pwmActive1), .pwmLastStep1(pwmLastStep1),
    .cycleDone(cycleDone), .busy(busy)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_printed = 0;

  // Reference model: mode 0 idle, 1 arm, 2 run, 3 drain; position counts up within a step.
  int     m_mode = 0;
  int     m_step = 0;
  longint m_pos  = 0;
  longint m_len  = MIN_LEN;
  bit     m_dir  = 1'b0;
  bit     m_pend = 1'b0;
  bit     m_init = 1'b0;

  function automatic longint clamp_len(input logic [CNT_W-1:0] r);
    return (longint'(r) < MIN_LEN) ? longint'(MIN_LEN) : longint'(r);
  endfunction

  function automatic int closing(input bit d);
    return d ? 0 : 11;
  endfunction

  task automatic m_go_idle();
    m_mode = 0; m_step = 0; m_pos = 0; m_pend = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_go_idle();
      m_len  = MIN_LEN;
      m_init = 1'b1;
    end else if (m_init) begin
      case (m_mode)
        0: if (start && !fault) m_mode = 1;
        1: begin
          if (fault) m_go_idle();
          else begin
            m_len = clamp_len(m3r_stepLen); m_dir = dir;
            m_step = dir ? 11 : 0; m_pos = 0; m_mode = 2;
          end
        end
        default: begin
          if (fault) m_go_idle();
          else begin
            if (m_mode == 2 && stop) m_pend = 1'b1;
            if (m_pos == m_len - 1) begin
              if (m_mode == 3) m_go_idle();
              else begin
                m_dir  = dir;
                m_step = dir ? (m_step + 11) % 12 : (m_step + 1) % 12;
                m_len  = clamp_len(m3r_stepLen);
                m_pos  = 0;
                if (m_pend && m_step == closing(m_dir)) m_mode = 3;
              end
            end else begin
              m_pos++;
              if (m_mode == 2 && m_pend && m_step == closing(m_dir)) m_mode = 3;
            end
          end
        end
      endcase
    end
  end

  function automatic logic [36:0] model_vec();
    bit act;
    bit l1;
    logic [CNT_W-1:0] ec;
    logic [3:0] es;
    act = (m_mode >= 2);
    ec = '0;
    es = 4'd0;
    if (act) begin
      ec = CNT_W'(m_len - 1 - m_pos);
      es = 4'(m_step);
    end
    l1 = act && (m_pos == m_len - 1);
    return {m_mode != 0, act, m_mode == 3, l1 && (m_step == closing(m_dir)),
            act && (m_pos == 0), act && (m_pos == 1), act && (m_pos == m_len - 2), l1,
            es, ec};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {busy, pwmActive1, pwmLastStep1, cycleDone, m3cntFirst2, m3cntFirst1,
            m3cntLast2, m3cntLast1, sgStep, m3cnt};
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      logic [36:0] e;
      logic [36:0] a;
      e = model_vec();
      a = dut_vec();
      checks++;
      if (a !== e) begin
        errors++;
        if (n_printed < 20) begin
          n_printed++;
          $display("FAIL cycle_cmp t=%0t got busy/act/last/cd/f2/f1/l2/l1=%b step=%0d cnt=%0d expected %b step=%0d cnt=%0d",
                   $time, a[36:29], a[28:25], a[24:0], e[36:29], e[28:25], e[24:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_active(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (pwmActive1) ok = 1'b1;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_step(input string name, input int s, input int c, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (sgStep == 4'(s) && m3cnt == CNT_W'(c)) ok = 1'b1;
    end
    chk(name, ok, 1);
  endtask

  task automatic fault_pulse();
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
  endtask

  initial begin
    int n_f2, n_f1, n_l2, n_l1, bad_pos, cd_at, n_last, n_cd, n_len, last_step;
    bit idle;
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; dir = 1'b0;
    m3r_stepLen = CNT_W'(100);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", m3cnt, 0);
    chk("reset_step", sgStep, 0);
    rst = 1'b0; start = 1'b1;

    // T1: one full forward cycle with L=100
    @(negedge clk);
    chk("t1_arm_busy", busy, 1);
    chk("t1_arm_active", pwmActive1, 0);
    start = 1'b0;
    @(negedge clk);
    chk("t1_first_cnt", m3cnt, 99);
    chk("t1_first2", m3cntFirst2, 1);
    chk("t1_first_active", pwmActive1, 1);
    n_f2 = 0; n_f1 = 0; n_l2 = 0; n_l1 = 0; bad_pos = 0; cd_at = 0;
    for (int k = 1; k <= 1200; k++) begin
      if (k > 1) @(negedge clk);
      n_f2 += int'(m3cntFirst2); n_f1 += int'(m3cntFirst1);
      n_l2 += int'(m3cntLast2);  n_l1 += int'(m3cntLast1);
      if ((m3cntFirst2 && m3cnt != 99) || (m3cntFirst1 && m3cnt != 98) ||
          (m3cntLast2 && m3cnt != 1) || (m3cntLast1 && m3cnt != 0)) bad_pos++;
      if (cycleDone && cd_at == 0) cd_at = k;
    end
    chk("t1_cycledone_clk", cd_at, 1200);
    chk("t1_first2_count", n_f2, 12);
    chk("t1_first1_count", n_f1, 12);
    chk("t1_last2_count", n_l2, 12);
    chk("t1_last1_count", n_l1, 12);
    chk("t1_strobe_pos", bad_pos, 0);
    chk("t1_final_step", sgStep, 11);

    // T2: stop pulse during step 4 drains through step 11
    wait_step("t2_reach_step4", 4, 50, 2000);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_last = 0; n_cd = 0; idle = 1'b0;
    for (int k = 0; k < 2000 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
      else begin
        n_last += int'(pwmLastStep1);
        n_cd += int'(cycleDone);
      end
    end
    chk("t2_idle", idle, 1);
    chk("t2_laststep_clks", n_last, 100);
    chk("t2_cycledone", n_cd, 1);
    chk("t2_idle_active", pwmActive1, 0);
    chk("t2_idle_step", sgStep, 0);

    // T3: fault at step 7, m3cnt=37
    start = 1'b1;
    wait_active("t3_start");
    start = 1'b0;
    wait_step("t3_reach_step7", 7, 37, 1000);
    fault = 1'b1;
    @(negedge clk);
    chk("t3_abort_outputs", dut_vec(), 0);
    fault = 1'b0; start = 1'b1;
    wait_active("t3_restart");
    start = 1'b0;
    chk("t3_restart_step", sgStep, 0);
    chk("t3_restart_cnt", m3cnt, 99);

    // T4: clamp to MIN_LEN, new length only at the boundary
    fault_pulse();
    m3r_stepLen = CNT_W'(3); start = 1'b1;
    wait_active("t4_start");
    start = 1'b0;
    chk("t4_clamped_cnt", m3cnt, 7);
    m3r_stepLen = CNT_W'(500);
    n_len = 1;
    for (int k = 0; k < 20 && sgStep == 4'd0; k++) begin
      @(negedge clk);
      if (sgStep == 4'd0) n_len++;
    end
    chk("t4_step0_len", n_len, 8);
    chk("t4_step1_cnt", m3cnt, 499);
    chk("t4_step1_idx", sgStep, 1);

    // T5: reverse direction, mid-step flip, closing step 0
    fault_pulse();
    dir = 1'b1; m3r_stepLen = CNT_W'(20); start = 1'b1;
    wait_active("t5_start");
    start = 1'b0;
    chk("t5_first_step", sgStep, 11);
    wait_step("t5_reach_step5", 5, 10, 400);
    dir = 1'b0;
    for (int k = 0; k < 40 && sgStep == 4'd5; k++) @(negedge clk);
    chk("t5_flip_step", sgStep, 6);
    dir = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_last = 0; last_step = -1; idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
      else if (pwmLastStep1) begin
        n_last++;
        last_step = int'(sgStep);
      end
    end
    chk("t5_idle", idle, 1);
    chk("t5_laststep_clks", n_last, 20);
    chk("t5_closing_step", last_step, 0);

    // T6: reset in DRAIN with start held, then rst+fault together
    dir = 1'b0; m3r_stepLen = CNT_W'(8); start = 1'b1;
    wait_active("t6_start");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 300 && !idle; k++) begin
      @(negedge clk);
      if (pwmLastStep1) idle = 1'b1;
    end
    chk("t6_reach_drain", idle, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_outputs", dut_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_arm_busy", busy, 1);
    chk("t6_arm_active", pwmActive1, 0);
    @(negedge clk);
    chk("t6_run_cnt", m3cnt, 7);
    rst = 1'b1; fault = 1'b1;
    @(negedge clk);
    chk("t6_rst_fault_outputs", dut_vec(), 0);
    rst = 1'b0; fault = 1'b0; start = 1'b0;

    // Largest legal step length
    m3r_stepLen = '1; start = 1'b1;
    wait_active("max_start");
    start = 1'b0;
    chk("max_len_cnt", m3cnt, (64'd1 << CNT_W) - 2);
    fault_pulse();

    // Random traffic against the model
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      fault = ($urandom_range(0, 199) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) dir = ~dir;
      m3r_stepLen = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 3))
                                                 : CNT_W'($urandom_range(5, 16));
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
